// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin grant, valid/ready on both sides, one registered result in flight.
// Optional per-requester grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
  parameter int unsigned NBIT = 8,
  parameter int unsigned OPW  = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [NBIT-1:0] req0_a,
  input  logic [NBIT-1:0] req0_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [NBIT-1:0] rsp0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [NBIT-1:0] req1_a,
  input  logic [NBIT-1:0] req1_b,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [NBIT-1:0] rsp1_data,
  output logic [OPW-1:0]  alu_op,
  output logic [NBIT-1:0] alu_in_a,
  output logic [NBIT-1:0] alu_in_b,
  input  logic [NBIT-1:0] alu_out
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNTW-1:0] gnt0_cnt,
  output logic [CNTW-1:0] gnt1_cnt
`endif
);

  typedef enum logic {StIdle, StResp} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;   // 1: requester 1 was granted last
  logic [NBIT-1:0] data_q, data_d;

  logic gnt0, gnt1;
  logic can_accept, accept;

  // Round-robin grant: a tie goes to the requester not granted last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt0 = last_q;
      gnt1 = ~last_q;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  // A new op fits when nothing is held or the held result leaves this cycle.
  always_comb begin
    can_accept = 1'b0;
    unique case (state_q)
      StIdle:  can_accept = 1'b1;
      StResp:  can_accept = owner_q ? rsp1_ready : rsp0_ready;
      default: can_accept = 1'b0;
    endcase
    accept = can_accept & (gnt0 | gnt1);
  end

  // Handshake and ALU drive; RST_N gating keeps them quiet while reset is asserted.
  always_comb begin
    req0_ready = RST_N & can_accept & gnt0;
    req1_ready = RST_N & can_accept & gnt1;
    alu_op     = '0;
    alu_in_a   = '0;
    alu_in_b   = '0;
    if (req0_ready) begin
      alu_op   = req0_op;
      alu_in_a = req0_a;
      alu_in_b = req0_b;
    end else if (req1_ready) begin
      alu_op   = req1_op;
      alu_in_a = req1_a;
      alu_in_b = req1_b;
    end
  end

  // Next state: load a new result on accept, otherwise drain the held one.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    data_d  = data_q;
    if (accept) begin
      state_d = StResp;
      owner_d = gnt1;
      last_d  = gnt1;
      data_d  = alu_out;
    end else if (state_q == StResp && can_accept) begin
      state_d = StIdle;
    end
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  // Response side: only the owner sees valid; data is held until taken.
  always_comb begin
    rsp0_valid = (state_q == StResp) & ~owner_q;
    rsp1_valid = (state_q == StResp) & owner_q;
    rsp0_data  = data_q;
    rsp1_data  = data_q;
  end

`ifdef ALU_ARB_STATS_EN
  logic [CNTW-1:0] cnt0_q, cnt1_q;

  // Saturating accepted-op counters per requester.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (accept && gnt0 && !(&cnt0_q)) cnt0_q <= cnt0_q + CNTW'(1);
      if (accept && gnt1 && !(&cnt1_q)) cnt1_q <= cnt1_q + CNTW'(1);
    end
  end

  assign gnt0_cnt = cnt0_q;
  assign gnt1_cnt = cnt1_q;
`else
  // Counter width only matters when the stats counters are built.
  if (CNTW == 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level model.
// Stats checks are compiled in when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

  localparam int unsigned NBIT = 8;
  localparam int unsigned OPW  = 4;
  localparam int unsigned CNTW = 3;

  logic            CLK, RST_N;
  logic            req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic [OPW-1:0]  req0_op;
  logic [NBIT-1:0] req0_a, req0_b, rsp0_data;
  logic            req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [OPW-1:0]  req1_op;
  logic [NBIT-1:0] req1_a, req1_b, rsp1_data;
  logic [OPW-1:0]  alu_op;
  logic [NBIT-1:0] alu_in_a, alu_in_b, alu_out;
`ifdef ALU_ARB_STATS_EN
  logic [CNTW-1:0] gnt0_cnt, gnt1_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: one held result, its owner, last grant, op counts.
  bit              m_held;
  int              m_own, m_last, last_g;
  logic [NBIT-1:0] m_res;
  int              m_cnt [2];

  function automatic logic [NBIT-1:0] alu_fn(logic [OPW-1:0] op, logic [NBIT-1:0] a,
                                             logic [NBIT-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << 1;
      default: return ~a;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_op, alu_in_a, alu_in_b);

  alu_arbiter #(.NBIT(NBIT), .OPW(OPW), .CNTW(CNTW)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
    .alu_op     (alu_op),
    .alu_in_a   (alu_in_a),
    .alu_in_b   (alu_in_b),
    .alu_out    (alu_out)
`ifdef ALU_ARB_STATS_EN
    ,
    .gnt0_cnt   (gnt0_cnt),
    .gnt1_cnt   (gnt1_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held    = 1'b0;
    m_own     = 0;
    m_last    = 1;
    m_res     = '0;
    m_cnt[0]  = 0;
    m_cnt[1]  = 0;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  // One clock: check combinational outputs at the falling edge, then advance the model.
  task automatic step();
    int              g;
    bit              can, acc;
    logic [OPW-1:0]  eop;
    logic [NBIT-1:0] ea, eb;
    @(negedge CLK);
    can = !m_held || ((m_own == 0) ? rsp0_ready : rsp1_ready);
    g = -1;
    if (req0_valid && req1_valid) g = 1 - m_last;
    else if (req0_valid)          g = 0;
    else if (req1_valid)          g = 1;
    acc = can && (g >= 0);
    eop = '0; ea = '0; eb = '0;
    if (acc && g == 0) begin eop = req0_op; ea = req0_a; eb = req0_b; end
    if (acc && g == 1) begin eop = req1_op; ea = req1_a; eb = req1_b; end
    check_eq("req0_ready", 32'(req0_ready), 32'(acc && g == 0));
    check_eq("req1_ready", 32'(req1_ready), 32'(acc && g == 1));
    check_eq("alu_op", 32'(alu_op), 32'(eop));
    check_eq("alu_in_a", 32'(alu_in_a), 32'(ea));
    check_eq("alu_in_b", 32'(alu_in_b), 32'(eb));
    check_eq("rsp0_valid", 32'(rsp0_valid), 32'(m_held && m_own == 0));
    check_eq("rsp1_valid", 32'(rsp1_valid), 32'(m_held && m_own == 1));
    if (m_held && m_own == 0) check_eq("rsp0_data", 32'(rsp0_data), 32'(m_res));
    if (m_held && m_own == 1) check_eq("rsp1_data", 32'(rsp1_data), 32'(m_res));
`ifdef ALU_ARB_STATS_EN
    check_eq("gnt0_cnt", 32'(gnt0_cnt), 32'(m_cnt[0]));
    check_eq("gnt1_cnt", 32'(gnt1_cnt), 32'(m_cnt[1]));
`endif
    @(posedge CLK);
    last_g = acc ? g : -1;
    if (acc) begin
      m_held = 1'b1;
      m_own  = g;
      m_last = g;
      m_res  = alu_fn(eop, ea, eb);
      if (m_cnt[g] < (1 << CNTW) - 1) m_cnt[g]++;
    end else if (can) begin
      m_held = 1'b0;
    end
    #1;
  endtask

  // Assert reset mid-cycle, check outputs while it is low, then release.
  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_eq("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check_eq("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check_eq("rst_rsp0_data", 32'(rsp0_data), 32'd0);
    check_eq("rst_rsp1_data", 32'(rsp1_data), 32'd0);
    check_eq("rst_req0_ready", 32'(req0_ready), 32'd0);
    check_eq("rst_req1_ready", 32'(req1_ready), 32'd0);
    check_eq("rst_alu_op", 32'(alu_op), 32'd0);
    check_eq("rst_alu_in_a", 32'(alu_in_a), 32'd0);
    idle_inputs();
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [NBIT-1:0] held;
    logic [NBIT-1:0] exp_q [$];
    RST_N = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    do_reset();

    // Single op: 5 + 3 accepted immediately, result next cycle.
    req0_valid = 1'b1; req0_op = 4'd0; req0_a = 8'h05; req0_b = 8'h03; rsp0_ready = 1'b1;
    step();
    check_eq("single_grant", 32'(last_g), 32'd0);
    req0_valid = 1'b0;
    check_eq("single_valid", 32'(rsp0_valid), 32'd1);
    check_eq("single_data", 32'(rsp0_data), 32'h08);
    step();

    // Tie from reset: order 0,1,0.
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_op = 4'd1; req0_a = 8'h20; req0_b = 8'h01;
    req1_op = 4'd4; req1_a = 8'hF0; req1_b = 8'h0F;
    step(); check_eq("tie_g0", 32'(last_g), 32'd0);
    step(); check_eq("tie_g1", 32'(last_g), 32'd1);
    step(); check_eq("tie_g2", 32'(last_g), 32'd0);

    // Backpressure on requester 0: result held, nothing accepted.
    rsp0_ready = 1'b0;
    held = rsp0_data;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("bp_no_accept", 32'(last_g), 32'hFFFF_FFFF);
      check_eq("bp_data_hold", 32'(rsp0_data), 32'(held));
    end
    rsp0_ready = 1'b1;
    step();
    check_eq("bp_release_g", 32'(last_g), 32'd1);
    idle_inputs();
    rsp1_ready = 1'b1;
    step();

    // Back-to-back stream on requester 1.
    rsp1_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        req1_valid = 1'b1;
        req1_op = OPW'($urandom_range(0, 7));
        req1_a  = NBIT'($urandom);
        req1_b  = NBIT'($urandom);
        exp_q.push_back(alu_fn(req1_op, req1_a, req1_b));
      end else begin
        req1_valid = 1'b0;
      end
      step();
      if (i < 5) check_eq("b2b_accept", 32'(last_g), 32'd1);
      if (i > 0 || i < 5) begin
        check_eq("b2b_valid", 32'(rsp1_valid), 32'(i < 5));
        if (i < 5) check_eq("b2b_data", 32'(rsp1_data), 32'(exp_q.pop_front()));
      end
    end

    // Reset while requester 0 holds a result, then a tie goes to requester 0.
    req0_valid = 1'b1; req0_op = 4'd2; req0_a = 8'h3C; req0_b = 8'hF5; rsp0_ready = 1'b0;
    step();
    check_eq("pre_rst_valid", 32'(rsp0_valid), 32'd1);
    req1_valid = 1'b1;
    do_reset();
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step();
    check_eq("post_rst_tie", 32'(last_g), 32'd0);

`ifdef ALU_ARB_STATS_EN
    // 3 ops on requester 0, 2 on requester 1.
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_valid = (i < 3); req1_valid = (i >= 3);
      step();
    end
    idle_inputs();
    step();
    check_eq("stats_cnt0", 32'(gnt0_cnt), 32'd3);
    check_eq("stats_cnt1", 32'(gnt1_cnt), 32'd2);
`endif

    // Random traffic against the model; long enough to saturate small counters.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req0_valid = 1'($urandom);
      req1_valid = 1'($urandom);
      req0_op = OPW'($urandom); req0_a = NBIT'($urandom); req0_b = NBIT'($urandom);
      req1_op = OPW'($urandom); req1_a = NBIT'($urandom); req1_b = NBIT'($urandom);
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      step();
    end

`ifdef ALU_ARB_STATS_EN
    check_eq("stats_sat0", 32'(gnt0_cnt), 32'((1 << CNTW) - 1));
    check_eq("stats_sat1", 32'(gnt1_cnt), 32'((1 << CNTW) - 1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
